// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, round counts,
// round constants and the RotWord helper.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } ks_state_t;

    localparam logic       AES_128 = 1'b0;
    localparam logic       AES_256 = 1'b1;
    localparam logic [3:0] NR_128  = 4'd10;
    localparam logic [3:0] NR_256  = 4'd14;

    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic byte_t rcon_byte(input logic [3:0] sel);
        return (sel < 4'd10) ? RCON[sel] : 8'h00;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-box lookups: SubWord on a 32-bit word, purely combinational.
module aes_sbox_word
    import aes_pkg::*;
(
    input  word_t word_in,
    output word_t word_out
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign word_out[gi*8 +: 8] = SBOX[word_in[gi*8 +: 8]];
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/256 key expansion: one round key per accepted beat,
// valid/ready on both the key input and the round-key output.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH  = 256,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_WIDTH-1:0]  key_in,
    input  logic                  key_len,
    input  logic                  key_valid_in,
    output logic                  key_ready_out,
    output logic [DATA_WIDTH-1:0] rk_out,
    output logic [3:0]            rk_idx,
    output logic                  rk_last,
    output logic                  rk_valid_out,
    input  logic                  rk_ready_in
);

    ks_state_t             state_reg, state_next;
    logic [DATA_WIDTH-1:0] a_reg, a_next;
    logic [DATA_WIDTH-1:0] b_reg, b_next;
    logic [3:0]            idx_reg, idx_next;
    logic                  len_reg, len_next;
    logic                  valid_reg, valid_next;
    logic                  last_reg, last_next;

    logic                  is_256;
    logic [3:0]            idx_new;
    logic [3:0]            nr;
    logic [3:0]            rcon_sel;
    word_t                 sub_in, sub_out, rcon_word, t_word;
    word_t                 c0, c1, c2, c3;
    logic [DATA_WIDTH-1:0] base_key, c_key;

    assign is_256  = (len_reg == AES_256);
    assign idx_new = idx_reg + 4'd1;
    assign nr      = is_256 ? NR_256 : NR_128;

    // AES-256 odd rounds skip RotWord and Rcon; only SubWord is applied.
    assign sub_in    = (is_256 && idx_new[0]) ? b_reg[31:0] : rot_word(b_reg[31:0]);
    assign rcon_sel  = is_256 ? ({1'b0, idx_new[3:1]} - 4'd1) : idx_reg;
    assign rcon_word = (is_256 && idx_new[0]) ? 32'h0 : {rcon_byte(rcon_sel), 24'h0};
    assign t_word    = sub_out ^ rcon_word;

    aes_sbox_word u_sbox (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    // AES-256 chains from the key two rounds back (A); AES-128 from the current one (B).
    always_comb begin
        base_key = is_256 ? a_reg : b_reg;
        c0 = base_key[127:96] ^ t_word;
        c1 = base_key[95:64]  ^ c0;
        c2 = base_key[63:32]  ^ c1;
        c3 = base_key[31:0]   ^ c2;
        c_key = (is_256 && idx_new == 4'd1) ? a_reg : {c0, c1, c2, c3};
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        len_next   = len_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (key_valid_in) begin
                    state_next = ST_EXPAND;
                    b_next     = key_in[KEY_WIDTH-1 -: DATA_WIDTH];
                    a_next     = key_in[DATA_WIDTH-1:0];
                    len_next   = key_len;
                    idx_next   = 4'd0;
                    valid_next = 1'b1;
                    last_next  = 1'b0;
                end
            end
            ST_EXPAND: begin
                if (valid_reg && rk_ready_in) begin
                    if (last_reg) begin
                        state_next = ST_IDLE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                    end else begin
                        a_next    = b_reg;
                        b_next    = c_key;
                        idx_next  = idx_new;
                        last_next = (idx_new == nr);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            len_reg   <= 1'b0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
        end
    end

    assign key_ready_out = (state_reg == ST_IDLE);
    assign rk_out        = b_reg;
    assign rk_idx        = idx_reg;
    assign rk_last       = last_reg;
    assign rk_valid_out  = valid_reg;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: a FIPS-style word-expansion model with an
// S-box derived from GF(2^8) inversion supplies every expected round key.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst_n;
    logic [255:0] key_in;
    logic         key_len;
    logic         key_valid_in;
    logic         key_ready_out;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         rk_valid_out;
    logic         rk_ready_in;

    aes_key_schedule dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_len       (key_len),
        .key_valid_in  (key_valid_in),
        .key_ready_out (key_ready_out),
        .rk_out        (rk_out),
        .rk_idx        (rk_idx),
        .rk_last       (rk_last),
        .rk_valid_out  (rk_valid_out),
        .rk_ready_in   (rk_ready_in)
    );

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   idx;
        logic         last;
        int           cyc;
        bit           timed;
    } beat_t;

    beat_t        sb_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           last_final_cyc = 0;
    bit           rdy_mode = 0;
    logic [7:0]   sbox_ref [256];
    logic [127:0] model_rk [15];
    logic [127:0] cap_rk [15];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeefcafef00d0123456789abcdef};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEYALT = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rk_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready_in = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return v[7] ? ({v[6:0], 1'b0} ^ 8'h1b) : {v[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_ref[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [255:0] key, input logic l, output int nr);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        int          nk;
        nk = l ? 8 : 4;
        nr = l ? 14 : 10;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word_ref({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                temp = sub_word_ref(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r <= nr; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_key(input logic [255:0] k, input logic l, input bit chk_gap);
        int    n, nr;
        beat_t b;
        key_in = k; key_len = l; key_valid_in = 1'b1;
        n = 0;
        @(negedge clk);
        while (!key_ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready_out) begin
            check_eq("accept_timeout", 128'(key_ready_out), 128'd1);
        end else begin
            if (chk_gap) check_eq("b2b_gap", 128'(cyc), 128'(last_final_cyc + 1));
            model_expand(k, l, nr);
            for (int r = 0; r <= nr; r++) begin
                b.rk = model_rk[r]; b.idx = 4'(r); b.last = (r == nr);
                b.cyc = cyc + 1 + r; b.timed = !rdy_mode;
                sb_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        key_valid_in = 1'b0;
        key_in = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (!(sb_q.size() == 0 && key_ready_out) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_done", 128'(sb_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() == 0) begin
                check_eq("valid_idle", 128'(rk_valid_out), 128'd0);
            end else if (rk_valid_out) begin
                check_eq("rk_value", rk_out, sb_q[0].rk);
                check_eq("rk_idx", 128'(rk_idx), 128'(sb_q[0].idx));
                check_eq("rk_last", 128'(rk_last), 128'(sb_q[0].last));
                check_eq("key_ready_busy", 128'(key_ready_out), 128'd0);
                if (rk_ready_in) begin
                    if (sb_q[0].timed) check_eq("beat_cycle", 128'(cyc), 128'(sb_q[0].cyc));
                    if (sb_q[0].last) last_final_cyc = cyc;
                    cap_rk[rk_idx] = rk_out;
                    $display("beat idx=%0d rk=%h last=%0b cyc=%0d", rk_idx, rk_out, rk_last, cyc);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; key_in = '0; key_len = 1'b0; key_valid_in = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_rk_out", rk_out, 128'd0);
        check_eq("reset_rk_idx", 128'(rk_idx), 128'd0);
        check_eq("reset_rk_last", 128'(rk_last), 128'd0);
        check_eq("reset_rk_valid", 128'(rk_valid_out), 128'd0);
        check_eq("reset_key_ready", 128'(key_ready_out), 128'd1);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // AES-128 known-answer run, ready held high
        send_key(KEY128, 1'b0, 1'b0);
        drain();
        check_eq("kat128_rk1", cap_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("kat128_rk10", cap_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-256 known-answer run
        send_key(KEY256, 1'b1, 1'b0);
        drain();
        check_eq("kat256_rk1", cap_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
        check_eq("kat256_rk2", cap_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        check_eq("kat256_rk14", cap_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Random backpressure on the AES-128 vector
        rdy_mode = 1'b1;
        send_key(KEY128, 1'b0, 1'b0);
        drain();
        rdy_mode = 1'b0;
        @(posedge clk); #1;

        // A different key offered mid-expansion must be ignored
        send_key(KEY128, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        key_in = KEYALT; key_len = 1'b1; key_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("busy_ready_low", 128'(key_ready_out), 128'd0);
        end
        @(posedge clk); #1;
        key_valid_in = 1'b0; key_in = '0;
        drain();

        // Reset asserted at rk_idx 5
        send_key(KEY256, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rk_valid_out && rk_idx == 4'd5) break;
        end
        check_eq("reached_idx5", 128'(rk_idx), 128'd5);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_eq("midrst_valid", 128'(rk_valid_out), 128'd0);
        check_eq("midrst_ready", 128'(key_ready_out), 128'd1);
        check_eq("midrst_idx", 128'(rk_idx), 128'd0);
        check_eq("midrst_rk", rk_out, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("postrst_no_beat", 128'(rk_valid_out), 128'd0);
        end
        @(posedge clk); #1;
        send_key(KEY128, 1'b0, 1'b0);
        drain();

        // Back-to-back: AES-256 key waiting while the AES-128 schedule runs
        send_key(KEY128, 1'b0, 1'b0);
        send_key(KEY256, 1'b1, 1'b1);
        drain();
        check_eq("b2b_rk14", cap_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
